skid_pipe_reg: RTL and testbench

SKID_PIPE_REG -- requirements
Module: skid_pipe_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/flopr_with_signal.sv | 26 ++
 rtl/skid_pipe_reg.sv | 115 +++++++++++
 tb/tb_skid_pipe_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared state encoding for the two-entry skid pipeline register.
// Rev     : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/flopr_with_signal.sv
`default_nettype none
// ============================================================================
// Module  : flopr_with_signal
// Brief   : WIDTH-bit register with load enable and async active-high reset.
// Rev     : 1.0 - initial release
// ============================================================================
module flopr_with_signal #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : flopr_with_signal
`default_nettype wire

// File: rtl/skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : skid_pipe_reg
// Brief   : Two-entry skid pipeline register; in_ready is registered-only.
//           Optional flush compiled in with SKID_PIPE_REG_FLUSH_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

`ifdef SKID_PIPE_REG_FLUSH_EN
  assign in_ready = (r_state != FULL) & ~flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign in_ready       = (r_state != FULL);
`endif

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = w_main_q;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Main refills from skid only when draining FULL; otherwise from upstream.
  assign w_main_d = (r_state == FULL) ? w_skid_q : in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_en   = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_en   = 1'b1;
        end else if (w_in_fire) begin
          w_skid_en   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_main_en   = 1'b1;
          w_state_nxt = ONE;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
`ifdef SKID_PIPE_REG_FLUSH_EN
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_en   = 1'b0;
      w_skid_en   = 1'b0;
    end
`endif
  end

  flopr_with_signal #(.WIDTH(WIDTH)) u_main_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_main_en),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  flopr_with_signal #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_skid_en),
    .d     (in_data),
    .q     (w_skid_q)
  );

endmodule : skid_pipe_reg
`default_nettype wire

// File: tb/tb_skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_skid_pipe_reg
// Brief   : Scoreboard bench for skid_pipe_reg (directed + random traffic).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_skid_pipe_reg;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [WIDTH-1:0] exp_q[$];

  skid_pipe_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got %h expected none", out_data);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // Input tracker runs just after the monitor so pops precede pushes/clears.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
    end else begin
`ifdef SKID_PIPE_REG_FLUSH_EN
      if (flush) exp_q.delete();
`endif
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    int bubbles;
    int dep_err;
    logic ir0, ir1;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    reset = 1'b0;

    // Simple pass
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    @(negedge clk);
    check("pass_pre_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("pass_valid", {31'd0, out_valid}, 32'd1);
    check("pass_data", out_data, 32'hA5A5_0001);
    tick();
    @(negedge clk);
    check("pass_empty", {31'd0, out_valid}, 32'd0);

    // Back-pressure into FULL, then drain
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_path", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head", out_data, 32'h11);
    tick();
    @(negedge clk);
    check("bp_hold", out_data, 32'h11);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_first", out_data, 32'h11);
    tick();
    @(negedge clk);
    check("bp_second", out_data, 32'h22);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming 100 words
    bubbles = 0;
    n_out = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1000 + i;
      @(negedge clk);
      if (i > 0 && !out_valid) bubbles++;
      if (!in_ready) bubbles++;
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", {31'd0, out_valid}, 32'd1);
    check("stream_last_data", out_data, 32'h1063);
    tick();
    @(negedge clk);
    check("stream_bubbles", bubbles, 32'd0);
    check("stream_count", n_out, 32'd100);

    // Random traffic
    dep_err = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      #1; ir0 = in_ready;
      out_ready = ~out_ready;
      #1; ir1 = in_ready;
      out_ready = ~out_ready;
      if (ir0 !== ir1) dep_err++;
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("rand_comb_dep", dep_err, 32'd0);
    check("rand_sb_empty", exp_q.size(), 32'd0);

    // Flush while FULL with an offered word
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
    tick();
    in_data = 32'h55;
    tick();
    in_data = 32'h66; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
`ifdef SKID_PIPE_REG_FLUSH_EN
    check("flush_empty", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
`else
    check("noflush_valid", {31'd0, out_valid}, 32'd1);
    check("noflush_head", out_data, 32'h44);
`endif
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("flush_sb_empty", exp_q.size(), 32'd0);

    // Async reset while FULL
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_data = 32'h88;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    @(negedge clk);
    check("arst_pre_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_post_valid", {31'd0, out_valid}, 32'd1);
    check("arst_post_data", out_data, 32'h33);
    repeat (2) tick();
    @(negedge clk);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_skid_pipe_reg
`default_nettype wire
